// File: rtl/muldiv_unit_pkg.sv
// Shared codes for the iterative multiply/divide unit.
//   muldiv_op_t    : operation select driven by the ALU decode
//   muldiv_state_t : sequencer states of muldiv_unit
//   op_is_signed / op_is_div : operation classification helpers
package muldiv_unit_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FIXUP = 2'd2
   } muldiv_state_t;

   function automatic logic op_is_signed(input muldiv_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic op_is_div(input muldiv_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the ALU (master) and muldiv_unit (slave).
//   start_i, op_i, rs_i, rt_i : operation request and operands
//   mthi_i, mtlo_i, wdata_i   : direct HI/LO writes
//   busy_o, done_o            : operation in flight / one-cycle completion pulse
//   hi_o, lo_o                : HI/LO register contents
interface muldiv_unit_if #(
   parameter int unsigned WIDTH = 32
) ();
   import muldiv_unit_pkg::*;

   logic             start_i;
   muldiv_op_t       op_i;
   logic [WIDTH-1:0] rs_i;
   logic [WIDTH-1:0] rt_i;
   logic             mthi_i;
   logic             mtlo_i;
   logic [WIDTH-1:0] wdata_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i, wdata_i,
      input  busy_o, done_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i, wdata_i,
      output busy_o, done_o, hi_o, lo_o
   );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Radix-2 shift-add multiplier and restoring divider sharing one adder and a
// 2*WIDTH accumulator. Fixed latency: accept edge T, done_o and the new HI/LO
// visible in the cycle after edge T+WIDTH, idle again one cycle later.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : muldiv_unit_if slave (start/op/operands, MTHI/MTLO, busy/done, HI/LO)
// WIDTH must be at least 2.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic          clk,
   input logic          reset,
   muldiv_unit_if.slave bus
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   muldiv_state_t      state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;     // mult: {partial, multiplier}; div: {rem, quot}
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               neg_quot_q, neg_quot_d;
   logic               neg_rem_q, neg_rem_d;
   logic               div0_q, div0_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   // Operand capture
   logic             signed_op;
   logic             rs_neg, rt_neg;
   logic [WIDTH-1:0] rs_mag, rt_mag;

   always_comb begin
      signed_op = op_is_signed(bus.op_i);
      rs_neg    = signed_op & bus.rs_i[WIDTH-1];
      rt_neg    = signed_op & bus.rt_i[WIDTH-1];
      // -(most negative) wraps back to itself, which is the correct unsigned magnitude
      rs_mag    = rs_neg ? -bus.rs_i : bus.rs_i;
      rt_mag    = rt_neg ? -bus.rt_i : bus.rt_i;
   end

   // One iteration of the shared datapath
   logic [WIDTH:0]     add_a, add_b, add_s;
   logic               no_borrow;
   logic [2*WIDTH-1:0] iter;

   always_comb begin
      // Divide works on the remainder already shifted left by one
      add_a     = is_div_q ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b     = {1'b0, opnd_q};
      add_s     = add_a + (is_div_q ? ~add_b : add_b) + {{WIDTH{1'b0}}, is_div_q};
      no_borrow = ~add_s[WIDTH];
      if (is_div_q) begin
         iter = {(no_borrow ? add_s[WIDTH-1:0] : add_a[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], no_borrow};
      end else if (acc_q[0]) begin
         iter = {add_s, acc_q[WIDTH-1:1]};
      end else begin
         iter = {1'b0, acc_q[2*WIDTH-1:1]};
      end
   end

   // Sign correction applied to the final iteration so HI/LO are already
   // valid during the FIXUP cycle that carries done_o.
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot, rem;
   logic [WIDTH-1:0]   res_hi, res_lo;

   always_comb begin
      prod = neg_quot_q ? -iter : iter;
      quot = iter[WIDTH-1:0];
      rem  = iter[2*WIDTH-1:WIDTH];
      if (!is_div_q) begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end else if (div0_q) begin
         res_hi = '0;
         res_lo = '0;
      end else begin
         res_hi = neg_rem_q  ? -rem  : rem;
         res_lo = neg_quot_q ? -quot : quot;
      end
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      div0_d     = div0_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d    = RUN;
               cnt_d      = CntLast;
               is_div_d   = op_is_div(bus.op_i);
               neg_quot_d = rs_neg ^ rt_neg;
               neg_rem_d  = rs_neg;
               div0_d     = op_is_div(bus.op_i) && (bus.rt_i == '0);
               if (op_is_div(bus.op_i)) begin
                  acc_d  = {{WIDTH{1'b0}}, rs_mag};
                  opnd_d = rt_mag;
               end else begin
                  acc_d  = {{WIDTH{1'b0}}, rt_mag};
                  opnd_d = rs_mag;
               end
            end else begin
               if (bus.mthi_i) hi_d = bus.wdata_i;
               if (bus.mtlo_i) lo_d = bus.wdata_i;
            end
         end
         RUN: begin
            acc_d = iter;
            if (cnt_q == '0) begin
               state_d = FIXUP;
               hi_d    = res_hi;
               lo_d    = res_lo;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         FIXUP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         opnd_q     <= '0;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         div0_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         div0_q     <= div0_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign bus.busy_o = (state_q != IDLE);
   assign bus.done_o = (state_q == FIXUP);
   assign bus.hi_o   = hi_q;
   assign bus.lo_o   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit that owns the HI/LO register pair. It replaces the single-cycle MULT/MULTU/DIV/DIVU path and HI/LO register in the ALU. Uses a radix-2 shift-add multiplier and a restoring divider, with a start/busy/done handshake. The decode/stall logic holds MFHI/MFLO, and any new muldiv op, while busy_o is high.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start_i  input  1  request a new operation; sampled only in IDLE.
op_i  input  muldiv_op_t (2)  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
rs_i  input  WIDTH  multiplicand / dividend.
rt_i  input  WIDTH  multiplier / divisor.
mthi_i  input  1  write wdata_i to HI.
mtlo_i  input  1  write wdata_i to LO.
wdata_i  input  WIDTH  MTHI/MTLO data.
busy_o  output  1  operation in flight.
done_o  output  1  one-cycle pulse; HI/LO hold the new result.
hi_o  output  WIDTH  HI register.
lo_o  output  WIDTH  LO register.

Behaviour:
Reset (asynchronous, any state):
- state <= IDLE; hi_o, lo_o, busy_o, done_o <= 0.
- All internal operand, accumulator and count registers <= 0.
- An in-flight operation is discarded with no partial result visible.

States:
- IDLE -> RUN when start_i=1. Latches the operation and operands (below); busy_o goes to 1 on the next edge.
- RUN: one iteration per cycle for exactly WIDTH cycles (counter from WIDTH-1 down to 0); goes to FIXUP after count 0.
- FIXUP: applies the sign correction, writes HI/LO, pulses done_o=1 for this single cycle, deasserts busy_o, returns to IDLE.
- busy_o is 1 throughout RUN and FIXUP.

Latency:
- Accept edge T; done_o=1 and new hi_o/lo_o visible in cycle T+WIDTH+1.
- A new start_i is accepted in the cycle after done_o, giving back-to-back throughput of one op per WIDTH+2 cycles.
- Latency is fixed for every op and operand value, including divide by zero. There is no early-out.

Operand capture at accept:
- Signed ops (MD_MULT, MD_DIV) latch the magnitudes |rs_i| and |rt_i|, plus neg_q = sign(rs) xor sign(rt) and neg_r = sign(rs).
- Unsigned ops latch the raw values with both negate flags cleared.
- The magnitude of the most negative value is 2^(WIDTH-1), held as unsigned.

Multiply:
- Each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half of the 2*WIDTH accumulator.
- Shift right one bit, keeping the carry.
- FIXUP: the product is negated in 2*WIDTH bits if neg_q; {hi,lo} <= product.

Divide:
- Restoring algorithm: shift the {rem, quot} pair left; trial-subtract the divisor from rem; keep the result and set the quotient bit if the subtraction does not borrow.
- FIXUP: lo <= quot, negated if neg_q; hi <= rem, negated if neg_r.
- The remainder takes the sign of the dividend, and quotient truncates toward zero.
- Corner case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.

Divide by zero:
- rt_i==0 at accept sets a div0 flag.
- RUN still lasts WIDTH cycles; FIXUP writes hi=lo=0.

MTHI/MTLO:
- Take effect on the edge when in IDLE and start_i=0.
- Both may be asserted in the same cycle; each updates its own register.
- Ignored while busy_o=1.
- Ignored when asserted together with start_i; the start wins.

Other rules:
- start_i while busy_o=1 is ignored and not queued.
- op_i, rs_i and rt_i are don't-care after the accept edge.
- hi_o/lo_o hold their old values during RUN and change only in FIXUP, by MTHI/MTLO, or by reset.

Decomposition:
- Add muldiv_op_t (2-bit enum MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) to the shared codes package, next to opcode_t and func_t.
- Add the muldiv_state_t enum (IDLE, RUN, FIXUP) to the same package.
- No sub-module. One FSM plus a shared 2*WIDTH+1-bit datapath, with mode-selected add/subtract, fits comfortably in a single module.
- The ALU drives start_i from FUNC_MULT/MULTU/DIV/DIVU decode and mthi_i/mtlo_i from FUNC_MTHI/FUNC_MTLO.

Test Plan:
- MD_MULT, rs=0xFFFFFFFD (-3), rt=5, start at T -> busy_o=1 for cycles T+1..T+33; done_o only at T+33 with hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MD_MULTU, rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MD_MULT of the same operands -> hi=0, lo=1.
- MD_DIVU 100/7 -> lo=14, hi=2. MD_DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. MD_DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- MD_DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. MD_DIVU 5/0 -> done at T+33 with hi=lo=0.
- MTHI 0x12345678 in IDLE -> hi_o=0x12345678 next cycle.
  - mthi_i and start_i in the same IDLE cycle -> hi_o changes only by the op result.
  - MTLO while busy -> lo_o unchanged.
  - A second start while busy -> ignored, exactly one done_o pulse.
- Assert reset at cycle T+10 of a MULT -> hi_o=lo_o=0, busy_o=0, and no done_o pulse.
  - After release, a fresh MULTU 6*7 -> lo=42, hi=0.
